mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the core's single memory port (address, data_out, data_in, we) between two requesters inside the multicycle core: instruction fetch (I, read-only) and load/store (D, read/write).
- Serialises accesses, owns the memory-side write enable and returns read data with a one-cycle valid pulse.
- Sits between the core FSM and the memory instance, so the memory interface is unchanged.

Parameters:
- MEM_LATENCY, 1, cycles from mem_address valid to mem_data_in valid for reads; legal range 0..7.
- PRIO_MODE, 0, 0 = round-robin between I and D; 1 = D always wins ties.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  32  fetched word.
- d_req  in  1  load/store request; held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store completed.
- d_rdata  out  32  load data; 0 on a store completion.
- mem_address  out  32  to memory address.
- mem_data_out  out  32  to memory data_in.
- mem_data_in  in  32  from memory data_out.
- mem_we  out  1  memory write enable.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_winner = I, latency counter 0. An in-flight transaction is abandoned with no rvalid. mem_we is 0 from the first posedge with reset high.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - gnt is combinational. If only one req is high, that requester wins.
  - If both are high: PRIO_MODE=0 picks the requester that is not last_winner; PRIO_MODE=1 picks D.
  - The winner's gnt is high for exactly that cycle, and gnt is gated low while reset=1.
  - On that edge, addr, we and wdata are captured into mem_address, mem_we and mem_data_out; owner and last_winner are updated; the counter is cleared; next state is ACCESS.
  - With no req, stay in IDLE with mem_we=0. mem_address and mem_data_out hold their last values.
- ACCESS, store (D only): mem_we=1 for exactly one cycle, then go to RESP.
- ACCESS, read: mem_we=0. The counter increments each cycle; when counter == MEM_LATENCY, mem_data_in is sampled into the owner's rdata and the state goes to RESP.
  - MEM_LATENCY=0 samples in the first ACCESS cycle.
- RESP: the owner's rvalid=1 for one cycle, mem_we=0, then return to IDLE. No gnt is issued in RESP.
- rdata holds its value until the next response to the same requester.
- Latency from gnt to rvalid: read = MEM_LATENCY+2 cycles; store = 2 cycles. The earliest next gnt is the cycle after rvalid.
- At most one transaction is in flight. A req raised during ACCESS or RESP waits and is never lost.
- A requester deasserting req before gnt withdraws the request without side effects.
- Addresses pass through unmodified; the arbiter does no alignment or range checks. The 0xFFC stop address and the address[11] output window are handled by memory and bench, not here.
- Both reqs arriving in the same cycle as a reset deassert: the first arbitration happens on the first cycle with reset=0.

Decomposition:
- Shared package `mem_pkg`:
  - state encoding typedef (IDLE/ACCESS/RESP);
  - owner enum (OWN_I, OWN_D);
  - constants DATA_W=32 and ADDR_W=32;
  - constant STOP_ADDR=32'hFFC for benches.
- One natural sub-module, `rr_picker`: a 2-input round-robin/fixed-priority selector (inputs req[1:0], last, mode; output grant[1:0]), purely combinational. The FSM, counter and response registers stay in mem_arbiter.

Test Plan:
- Single fetch, MEM_LATENCY=1, memory word 0x00000000 = 0x00500093, i_req with i_addr=0:
  - i_gnt at cycle t;
  - mem_address=0 from t+1;
  - i_rvalid at t+3 with i_rdata=0x00500093.
- Store, d_we=1, d_addr=0x800, d_wdata=0xDEADBEEF:
  - mem_we=1 exactly one cycle, at t+1;
  - d_rvalid at t+2 with d_rdata=0;
  - a subsequent load of 0x800 returns 0xDEADBEEF.
- Simultaneous i_req and d_req held 4 transactions each, PRIO_MODE=0: grants alternate D,I,D,I,... (first D because last_winner resets to I). With PRIO_MODE=1, all 4 D grants precede any I grant.
- Reset mid-read, MEM_LATENCY=3: assert reset in the second ACCESS cycle:
  - no i_rvalid ever appears;
  - all outputs are 0 one cycle later;
  - a fresh request after deassert completes normally.
- MEM_LATENCY=0 with back-to-back loads from 0x004 and 0x008: each d_rvalid is 2 cycles after its d_gnt, and the second d_gnt comes 1 cycle after the first d_rvalid.
- Request withdrawn: pulse i_req for one cycle while D is in ACCESS. No i_gnt occurs, no fetch access reaches memory, and no i_rvalid appears.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the core's instruction/data memory arbiter.
package mem_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    // Stop address watched by benches; the arbiter itself never decodes it.
    localparam logic [ADDR_W-1:0] STOP_ADDR = 32'hFFC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-way selector: bit 0 = fetch, bit 1 = load/store. On a tie, mode=1 favours D,
// otherwise the requester that did not win last time is chosen.
module rr_picker
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    input  logic       mode,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (mode || (last == OWN_I)) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (I) and load/store (D) onto the single memory port. Handshake: a
// requester holds req and its fields until gnt; the transfer is accepted on the posedge
// where req && gnt, and completes with a one-cycle rvalid pulse, gnt only in IDLE.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int PRIO_MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    output state_e            dbg_state
);
    localparam logic [2:0] LAT    = 3'(MEM_LATENCY);
    localparam logic       MODE_D = (PRIO_MODE != 0);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        grant;

    rr_picker u_picker (
        .req   ({d_req, i_req}),
        .last  (last_q),
        .mode  (MODE_D),
        .grant (grant)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        mem_we_d       = 1'b0;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        i_gnt          = 1'b0;
        d_gnt          = 1'b0;
        i_rvalid       = 1'b0;
        d_rvalid       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    i_gnt = grant[0];
                    d_gnt = grant[1];
                end
                if (d_gnt) begin
                    mem_address_d  = d_addr;
                    mem_data_out_d = d_wdata;
                    mem_we_d       = d_we;
                    owner_d        = OWN_D;
                    last_d         = OWN_D;
                    cnt_d          = 3'd0;
                    state_d        = ACCESS;
                end else if (i_gnt) begin
                    mem_address_d  = i_addr;
                    owner_d        = OWN_I;
                    last_d         = OWN_I;
                    cnt_d          = 3'd0;
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                // A registered write enable means this access is a store.
                if (mem_we_q) begin
                    d_rdata_d = '0;
                    state_d   = RESP;
                end else if (cnt_q == LAT) begin
                    if (owner_q == OWN_D) d_rdata_d = mem_data_in;
                    else                  i_rdata_d = mem_data_in;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                if (!reset) begin
                    i_rvalid = (owner_q == OWN_I);
                    d_rvalid = (owner_q == OWN_D);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= OWN_I;
            last_q         <= OWN_I;
            cnt_q          <= 3'd0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            mem_we_q       <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mem_we_q       <= mem_we_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
        end
    end

    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_we       = mem_we_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign dbg_state    = state_q;
endmodule
